mem_writeback_stage: RTL and testbench
======================================

Name: mem_writeback_stage

Overview:
- Consumer side of the execute-stage pipeline register in the 16-bit CPU.
- Each cycle it takes the EX outputs (result, destination address, reg_write, data_read).
- ALU results are written straight to the register file.
- Loads are issued to data memory over a req/ack handshake, and the returned word is written back.
- While a load is in flight, it stalls the upstream pipeline.

Parameters:
DATA_W, 16, width of result, memory data and writeback data
ADDR_W, 4, register-file address width
TIMEOUT, 15, max cycles in REQ waiting for mem_ack before abort (>=1)

Ports:
CLK  in  1  clock; all state updates on posedge CLK
RST  in  1  synchronous reset, active-high
result_in  in  DATA_W  ALU result; memory address when data_read_in=1
c_addr_in  in  ADDR_W  destination register
reg_write_in  in  1  instruction writes a register
data_read_in  in  1  instruction is a load
stall  out  1  upstream must hold its outputs; inputs ignored while 1
mem_req  out  1  memory read request
mem_addr  out  DATA_W  read address, stable while mem_req=1
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  read complete (single-cycle pulse)
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data
mem_err  out  1  sticky: a load timed out

Behaviour:
- Reset is synchronous and active-high on RST, clocked by CLK (one clock domain). When RST=1 at a posedge:
  - state=IDLE, timeout counter=0.
  - stall, mem_req, rf_we and mem_err all go to 0; mem_addr, rf_waddr and rf_wdata go to 0.
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- States: IDLE, REQ, WB. stall=1 exactly when state is REQ or WB.
- IDLE, at posedge:
  - data_read_in=1: latch addr=result_in, dest=c_addr_in, wb_en=reg_write_in; clear counter; go to REQ. mem_req=1 and mem_addr=addr from the next cycle.
  - data_read_in=0 and reg_write_in=1: next cycle rf_we=1, rf_waddr=c_addr_in, rf_wdata=result_in. Stay in IDLE; back-to-back ALU writes every cycle.
  - Both 0 (bubble): rf_we=0 next cycle.
- REQ:
  - mem_req=1, with mem_addr held.
  - mem_ack is sampled every REQ cycle, including the first.
  - On mem_ack=1: capture mem_rdata into the load buffer, go to WB. mem_req=0 from the next cycle.
  - No ack and counter==TIMEOUT-1: set mem_err, go to IDLE, no writeback.
  - Otherwise: counter+1.
- WB: rf_we=wb_en, rf_waddr=dest, rf_wdata=captured data, for exactly one cycle. Then go to IDLE.
- Latency:
  - ALU op: rf_we 1 cycle after acceptance.
  - Load with first-cycle ack: accepted at edge 0, REQ in cycle 1, WB in cycle 2 (rf_we=1), IDLE in cycle 3. stall is high in cycles 1-2.
- Load with reg_write_in=0: the read is still performed; no rf write.
- Register address 0 is written like any other.
- mem_ack outside REQ is ignored.
- mem_err stays set until RST; later loads proceed normally.
- RST during REQ or WB: the pending load is abandoned, mem_req=0 and rf_we=0 next cycle, and a later ack is ignored.
- rf_we=0 in every cycle not listed above.

Test Plan:
- Reset, then ALU ops: result_in=0x1234/c=3/rw=1, then 0xABCD/c=7/rw=1 on consecutive cycles -> rf_we=1 on the following two cycles with (3,0x1234), (7,0xABCD); stall stays 0.
- Load with immediate ack: data_read_in=1, result_in=0x0040, c=5, rw=1; ack in first REQ cycle with rdata=0xBEEF -> mem_req high 1 cycle, addr=0x0040; rf_we=1 with (5,0xBEEF) 2 cycles after acceptance; stall high 2 cycles.
- Load with ack delayed 4 cycles, inputs changing meanwhile -> mem_addr stable, changed inputs ignored; writeback uses the original dest and rdata; stall deasserts after WB.
- Timeout: load with no ack, TIMEOUT=15 -> mem_req high 15 cycles, mem_err=1, no rf_we. A following ALU op writes normally and mem_err stays 1.
- Reset mid-load: RST in the 2nd REQ cycle, then ack the next cycle -> mem_req=0, no rf_we, state IDLE, mem_err=0.
- Load with rw=0 and ack -> no rf_we; a stray mem_ack while IDLE -> no effect.

Source files
------------

// File: rtl/mem_writeback_stage.sv
// Writeback stage: retires ALU results straight into the register file and runs
// loads through a req/ack data-memory handshake, stalling upstream while one is in flight.
`timescale 1ns/1ps
module mem_writeback_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] result_in,
  input  logic [ADDR_W-1:0] c_addr_in,
  input  logic              reg_write_in,
  input  logic              data_read_in,
  output logic              stall,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_dest;
  logic                r_wb_en;
  logic                r_rf_we;
  logic [ADDR_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic                r_mem_err;
  logic                w_timeout;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Stage boundary: state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (data_read_in) w_next = S_REQ;
      S_REQ: begin
        if (mem_ack)        w_next = S_WB;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stage boundary: load context, timeout counter and register-file write port
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_dest     <= '0;
      r_wb_en    <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_rf_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (data_read_in) begin
            r_addr  <= result_in;
            r_dest  <= c_addr_in;
            r_wb_en <= reg_write_in;
            r_cnt   <= '0;
          end else if (reg_write_in) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= c_addr_in;
            r_rf_wdata <= result_in;
          end
        end
        S_REQ: begin
          // The write-data register doubles as the load buffer, so WB needs no extra copy.
          if (mem_ack) begin
            r_rf_we    <= r_wb_en;
            r_rf_waddr <= r_dest;
            r_rf_wdata <= mem_rdata;
          end else if (w_timeout) begin
            r_mem_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall    = (r_state != S_IDLE);
  assign mem_req  = (r_state == S_REQ);
  assign mem_addr = r_addr;
  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign mem_err  = r_mem_err;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Self-checking bench for mem_writeback_stage: directed scenarios plus a randomized
// run scored against a transaction-level register-file model.
`timescale 1ns/1ps
module tb_mem_writeback_stage;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 15;

  logic              CLK = 1'b0;
  logic              RST;
  logic [DATA_W-1:0] result_in;
  logic [ADDR_W-1:0] c_addr_in;
  logic              reg_write_in;
  logic              data_read_in;
  logic              stall;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              mem_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] dut_rf [16];
  logic [DATA_W-1:0] exp_rf [16];
  int                dut_writes;
  int                exp_writes;
  logic              mon_en = 1'b0;

  mem_writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .result_in(result_in), .c_addr_in(c_addr_in),
    .reg_write_in(reg_write_in), .data_read_in(data_read_in), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  // Observed register file, built from the write port.
  always @(posedge CLK) begin
    if (mon_en && rf_we) begin
      dut_rf[rf_waddr] = rf_wdata;
      dut_writes = dut_writes + 1;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle;
    result_in = '0; c_addr_in = '0; reg_write_in = 1'b0; data_read_in = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic drive_junk;
    result_in = 16'($urandom); c_addr_in = 4'($urandom);
    reg_write_in = 1'($urandom); data_read_in = 1'($urandom);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    drive_junk();
    data_read_in = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    tick();
    n_chk++; if (stall !== 1'b0)    begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_chk++; if (mem_req !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_chk++; if (rf_we !== 1'b0)    begin n_fail++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
    n_chk++; if (mem_err !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_err got %b exp 0", mem_err); end
    n_chk++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    n_chk++; if (rf_waddr !== 4'h0) begin n_fail++; $display("FAIL reset_rf_waddr got %h exp 0", rf_waddr); end
    n_chk++; if (rf_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_rf_wdata got %h exp 0", rf_wdata); end
    RST = 1'b0;
    drive_idle();
    tick();
  endtask

  task automatic test_alu;
    result_in = 16'h1234; c_addr_in = 4'd3; reg_write_in = 1'b1; data_read_in = 1'b0;
    tick();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 16'h1234})
      begin n_fail++; $display("FAIL alu1 got we=%b a=%h d=%h exp 1/3/1234", rf_we, rf_waddr, rf_wdata); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu1_stall got %b exp 0", stall); end
    result_in = 16'hABCD; c_addr_in = 4'd7;
    tick();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd7, 16'hABCD})
      begin n_fail++; $display("FAIL alu2 got we=%b a=%h d=%h exp 1/7/abcd", rf_we, rf_waddr, rf_wdata); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu2_stall got %b exp 0", stall); end
    drive_idle();
    result_in = 16'h5555; c_addr_in = 4'd9;
    tick();
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL bubble_we got %b exp 0", rf_we); end
    result_in = 16'h0F0F; c_addr_in = 4'd0; reg_write_in = 1'b1;
    tick();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd0, 16'h0F0F})
      begin n_fail++; $display("FAIL alu_r0 got we=%b a=%h d=%h exp 1/0/0f0f", rf_we, rf_waddr, rf_wdata); end
    drive_idle();
    tick();
  endtask

  task automatic test_load_immediate;
    result_in = 16'h0040; c_addr_in = 4'd5; reg_write_in = 1'b1; data_read_in = 1'b1;
    tick();
    n_chk++; if ({stall, mem_req, rf_we} !== 3'b110)
      begin n_fail++; $display("FAIL ldi_c1 got stall=%b req=%b we=%b exp 1/1/0", stall, mem_req, rf_we); end
    n_chk++; if (mem_addr !== 16'h0040) begin n_fail++; $display("FAIL ldi_addr got %h exp 0040", mem_addr); end
    drive_idle();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    n_chk++; if ({stall, mem_req} !== 2'b10)
      begin n_fail++; $display("FAIL ldi_c2 got stall=%b req=%b exp 1/0", stall, mem_req); end
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd5, 16'hBEEF})
      begin n_fail++; $display("FAIL ldi_wb got we=%b a=%h d=%h exp 1/5/beef", rf_we, rf_waddr, rf_wdata); end
    mem_ack = 1'b0;
    tick();
    n_chk++; if ({stall, rf_we} !== 2'b00)
      begin n_fail++; $display("FAIL ldi_c3 got stall=%b we=%b exp 0/0", stall, rf_we); end
  endtask

  task automatic test_load_delayed;
    result_in = 16'h1230; c_addr_in = 4'd9; reg_write_in = 1'b1; data_read_in = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_junk();
      mem_ack = 1'b0; mem_rdata = 16'($urandom);
      n_chk++; if ({stall, mem_req, rf_we} !== 3'b110 || mem_addr !== 16'h1230)
        begin n_fail++; $display("FAIL ldd_wait%0d got stall=%b req=%b we=%b addr=%h exp 1/1/0/1230", k, stall, mem_req, rf_we, mem_addr); end
      tick();
    end
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 16'h1230)
      begin n_fail++; $display("FAIL ldd_c5 got req=%b addr=%h exp 1/1230", mem_req, mem_addr); end
    drive_junk();
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    n_chk++; if ({stall, mem_req, rf_we, rf_waddr, rf_wdata} !== {3'b101, 4'd9, 16'h5A5A})
      begin n_fail++; $display("FAIL ldd_wb got stall=%b req=%b we=%b a=%h d=%h exp 1/0/1/9/5a5a", stall, mem_req, rf_we, rf_waddr, rf_wdata); end
    drive_idle();
    tick();
    n_chk++; if ({stall, rf_we} !== 2'b00)
      begin n_fail++; $display("FAIL ldd_end got stall=%b we=%b exp 0/0", stall, rf_we); end
  endtask

  task automatic test_timeout;
    int req_cycles;
    logic saw_we;
    result_in = 16'h0777; c_addr_in = 4'd2; reg_write_in = 1'b1; data_read_in = 1'b1;
    tick();
    drive_idle();
    n_chk++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL to_err_early got %b exp 0", mem_err); end
    req_cycles = 0;
    saw_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      req_cycles++;
      if (rf_we) saw_we = 1'b1;
      tick();
    end
    n_chk++; if (req_cycles != TIMEOUT)
      begin n_fail++; $display("FAIL to_req_cycles got %0d exp %0d", req_cycles, TIMEOUT); end
    n_chk++; if ({mem_err, stall, rf_we, saw_we} !== 4'b1000)
      begin n_fail++; $display("FAIL to_end got err=%b stall=%b we=%b sawwe=%b exp 1/0/0/0", mem_err, stall, rf_we, saw_we); end
    result_in = 16'h4321; c_addr_in = 4'd4; reg_write_in = 1'b1;
    tick();
    n_chk++; if ({rf_we, rf_waddr, rf_wdata, mem_err} !== {1'b1, 4'd4, 16'h4321, 1'b1})
      begin n_fail++; $display("FAIL to_alu got we=%b a=%h d=%h err=%b exp 1/4/4321/1", rf_we, rf_waddr, rf_wdata, mem_err); end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_midload;
    result_in = 16'h0100; c_addr_in = 4'd6; reg_write_in = 1'b1; data_read_in = 1'b1;
    tick();
    drive_idle();
    tick();
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rml_req2 got %b exp 1", mem_req); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_chk++; if ({mem_req, rf_we, stall, mem_err} !== 4'b0000)
      begin n_fail++; $display("FAIL rml_rst got req=%b we=%b stall=%b err=%b exp 0/0/0/0", mem_req, rf_we, stall, mem_err); end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    n_chk++; if ({mem_req, rf_we, stall} !== 3'b000)
      begin n_fail++; $display("FAIL rml_lateack got req=%b we=%b stall=%b exp 0/0/0", mem_req, rf_we, stall); end
    tick();
  endtask

  task automatic test_load_norw_stray;
    result_in = 16'h0200; c_addr_in = 4'd1; reg_write_in = 1'b0; data_read_in = 1'b1;
    tick();
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200)
      begin n_fail++; $display("FAIL norw_req got req=%b addr=%h exp 1/0200", mem_req, mem_addr); end
    drive_idle();
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    n_chk++; if ({stall, rf_we} !== 2'b10)
      begin n_fail++; $display("FAIL norw_wb got stall=%b we=%b exp 1/0", stall, rf_we); end
    mem_ack = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 1'b0;
    n_chk++; if ({stall, rf_we, mem_req} !== 3'b000)
      begin n_fail++; $display("FAIL stray_ack got stall=%b we=%b req=%b exp 0/0/0", stall, rf_we, mem_req); end
    tick();
  endtask

  task automatic test_random;
    logic [DATA_W-1:0] a, d;
    logic [ADDR_W-1:0] c;
    logic              rw;
    int                dly;
    int                kind;
    for (int r = 0; r < 16; r++) begin dut_rf[r] = '0; exp_rf[r] = '0; end
    dut_writes = 0; exp_writes = 0;
    mon_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      a = 16'($urandom); c = 4'($urandom); rw = 1'($urandom); d = 16'($urandom);
      if (kind < 2) begin
        result_in = a; c_addr_in = c; data_read_in = 1'b0;
        reg_write_in = (kind == 1);
        if (kind == 1) begin exp_rf[c] = a; exp_writes++; end
        tick();
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rnd_alu_stall op%0d got %b exp 0", n, stall); end
      end else begin
        dly = $urandom_range(0, 4);
        result_in = a; c_addr_in = c; reg_write_in = rw; data_read_in = 1'b1;
        tick();
        for (int k = 0; k <= dly; k++) begin
          drive_junk();
          mem_ack = (k == dly); mem_rdata = (k == dly) ? d : 16'($urandom);
          n_chk++; if (mem_req !== 1'b1 || mem_addr !== a || stall !== 1'b1)
            begin n_fail++; $display("FAIL rnd_req op%0d got req=%b addr=%h stall=%b exp 1/%h/1", n, mem_req, mem_addr, stall, a); end
          tick();
        end
        mem_ack = 1'b0;
        drive_junk();
        if (rw) begin exp_rf[c] = d; exp_writes++; end
        tick();
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rnd_ld_done op%0d stall got %b exp 0", n, stall); end
      end
    end
    drive_idle();
    tick();
    mon_en = 1'b0;
    n_chk++; if (dut_writes != exp_writes)
      begin n_fail++; $display("FAIL rnd_write_count got %0d exp %0d", dut_writes, exp_writes); end
    for (int r = 0; r < 16; r++) begin
      n_chk++; if (dut_rf[r] !== exp_rf[r])
        begin n_fail++; $display("FAIL rnd_rf[%0d] got %h exp %h", r, dut_rf[r], exp_rf[r]); end
    end
  endtask

  initial begin
    drive_idle();
    RST = 1'b1;
    test_reset();
    test_alu();
    test_load_immediate();
    test_load_delayed();
    test_timeout();
    test_reset_midload();
    test_load_norw_stray();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
